// File: rtl/integration_pkg.sv
// Shared AHB encodings and integration constants for the arbiter slice.
// Bus sizing is fixed here so every block of the harness agrees on it.
package integration_pkg;

   localparam int master_number = 4;
   localparam int HMASTER_W     = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      BUSY   = 2'b01,
      NONSEQ = 2'b10,
      SEQ    = 2'b11
   } htrans_t;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_t;

   typedef enum logic [1:0] {
      OKAY  = 2'b00,
      ERROR = 2'b01,
      RETRY = 2'b10,
      SPLIT = 2'b11
   } hresp_t;

   typedef enum logic [1:0] {
      ARB,
      BURST,
      LOCK
   } arb_state_t;

   // Beats after the first NONSEQ; zero marks SINGLE/INCR (no counter).
   function automatic logic [3:0] burst_beats_m1(input logic [2:0] b);
      case (b)
         WRAP4, INCR4:   return 4'd3;
         WRAP8, INCR8:   return 4'd7;
         WRAP16, INCR16: return 4'd15;
         default:        return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_arbiter_core_rr_select.sv
// Combinational round-robin picker: first set request at or after the
// pointer, wrapping modulo N.
module rr_select
   import integration_pkg::*;
#(
   parameter int N = master_number
)
(
   input  logic [N-1:0]                    i_req,
   input  logic [((N > 1) ? $clog2(N) : 1)-1:0] i_ptr,
   output logic [N-1:0]                    o_gnt,
   output logic                            o_valid
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [PW:0] NW = (PW+1)'(N);

   logic          w_found;
   logic [PW:0]   w_sum;
   logic [PW-1:0] w_idx;

   always_comb begin
      o_gnt   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_idx   = '0;
      for (int k = 0; k < N; k++) begin
         w_sum = {1'b0, i_ptr} + (PW+1)'(k);
         if (w_sum >= NW) w_sum = w_sum - NW;
         w_idx = w_sum[PW-1:0];
         if (!w_found && i_req[w_idx]) begin
            o_gnt[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
      o_valid = w_found;
   end

endmodule

// File: rtl/ahb_arbiter_core.sv
// AHB bus arbiter: round-robin grant with fixed-length burst hold and
// locked-transfer hold; hmaster/hmastlock trail hgrant by one accepted cycle.
module ahb_arbiter_core
   import integration_pkg::*;
(
   input  logic                       hclk,
   input  logic                       hreset,
   input  logic [master_number-1:0]   busreq,
   input  logic [master_number-1:0]   hlock,
   input  logic [2*master_number-1:0] htrans,
   input  logic [3*master_number-1:0] hburst,
   input  logic                       hready,
   input  logic [1:0]                 hresp,
   output logic [master_number-1:0]   hgrant,
   output logic [HMASTER_W-1:0]       hmaster,
   output logic                       hmastlock
);

   localparam int IDX_W = (master_number > 1) ? $clog2(master_number) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(master_number - 1);

   typedef logic [master_number-1:0] req_t;

   req_t             r_hgrant;
   logic [IDX_W-1:0] r_gidx;
   logic [IDX_W-1:0] r_oidx;
   logic [IDX_W-1:0] r_ptr;
   logic             r_mastlock;
   arb_state_t       r_state;
   logic [3:0]       r_cnt;

   req_t             w_win_oh;
   logic             w_win_vld;
   req_t             w_arb_oh;
   logic [IDX_W-1:0] w_arb_idx;
   logic [IDX_W-1:0] w_arb_ptr;
   logic [1:0]       w_tr [master_number];
   logic [2:0]       w_bu [master_number];
   logic [1:0]       w_own_tr;
   logic [3:0]       w_len;
   logic             w_start_burst;
   logic             w_last_beat;
   logic             w_do_arb;

   function automatic logic [IDX_W-1:0] oh2idx(input req_t oh);
      logic [IDX_W-1:0] r;
      r = '0;
      for (int i = 0; i < master_number; i++)
         if (oh[i]) r = IDX_W'(i);
      return r;
   endfunction

   function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] i);
      return (i == LAST_IDX) ? '0 : i + 1'b1;
   endfunction

   for (genvar g = 0; g < master_number; g++) begin : g_own
      assign w_tr[g] = htrans[2*g +: 2];
      assign w_bu[g] = hburst[3*g +: 3];
   end

   rr_select #(.N(master_number)) u_rr (
      .i_req   (busreq),
      .i_ptr   (r_ptr),
      .o_gnt   (w_win_oh),
      .o_valid (w_win_vld)
   );

   // With no requester the bus parks on master 0.
   always_comb begin
      w_arb_oh      = w_win_vld ? w_win_oh : req_t'(1);
      w_arb_idx     = oh2idx(w_arb_oh);
      w_arb_ptr     = inc_mod(w_arb_idx);
      w_own_tr      = w_tr[r_oidx];
      w_len         = burst_beats_m1(w_bu[r_oidx]);
      w_start_burst = hready && (r_state == ARB) && (w_own_tr == NONSEQ) && (w_len != 4'd0);
      w_last_beat   = hready && (r_state == BURST) && (w_own_tr == SEQ) && (r_cnt == 4'd1);
      w_do_arb      = (hready && (r_state == ARB) && !w_start_burst) || w_last_beat;
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         r_hgrant   <= req_t'(1);
         r_gidx     <= '0;
         r_oidx     <= '0;
         r_ptr      <= '0;
         r_mastlock <= 1'b0;
         r_state    <= ARB;
         r_cnt      <= '0;
      end else begin
         if (hready) begin
            r_oidx     <= r_gidx;
            r_mastlock <= hlock[r_gidx];
         end
         if (w_do_arb) begin
            r_hgrant <= w_arb_oh;
            r_gidx   <= w_arb_idx;
            r_ptr    <= w_arb_ptr;
         end
         case (r_state)
            ARB: begin
               if (w_start_burst) begin
                  r_state <= BURST;
                  r_cnt   <= w_len;
               end else if (w_do_arb && hlock[w_arb_idx]) begin
                  r_state <= LOCK;
               end
            end
            BURST: begin
               // The first ERROR/RETRY/SPLIT cycle (hready low) aborts the burst.
               if (!hready && (hresp != OKAY)) begin
                  r_state <= ARB;
                  r_cnt   <= '0;
               end else if (w_last_beat) begin
                  if (hlock[w_arb_idx]) r_state <= LOCK;
                  else                  r_state <= ARB;
                  r_cnt <= '0;
               end else if (hready) begin
                  if ((w_own_tr == IDLE) || (w_own_tr == NONSEQ)) begin
                     r_state <= ARB;
                     r_cnt   <= '0;
                  end else if (w_own_tr == SEQ) begin
                     r_cnt <= r_cnt - 4'd1;
                  end
               end
            end
            LOCK: begin
               if (hready && !hlock[r_gidx]) r_state <= ARB;
            end
            default: r_state <= ARB;
         endcase
      end
   end

   assign hgrant    = r_hgrant;
   assign hmaster   = HMASTER_W'(r_oidx);
   assign hmastlock = r_mastlock;

endmodule
